// File: rtl/uart_fifo_128x8_if.sv
// Handshake bundle between the UART register block and the 128x8 FIFO.
// Signal suffixes are named from the FIFO's point of view; strobes are active-low.
interface uart_fifo_128x8_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_i;
    logic              wrb_i;
    logic              rdb_i;
    logic [DATA_W-1:0] data_o;
    logic              full_o;
    logic              empty_o;
    logic              geqth_o;

    modport master (
        output data_i, wrb_i, rdb_i,
        input  data_o, full_o, empty_o, geqth_o
    );

    modport slave (
        input  data_i, wrb_i, rdb_i,
        output data_o, full_o, empty_o, geqth_o
    );
endinterface

// File: rtl/uart_fifo_128x8.sv
// 128x8 UART data FIFO: 1W/1R RAM with registered read address, FULL/EMPTY/GEQTH flags.
// Define FIFO_OVERFLOW_CHECK_EN to add a simulation-only overflow/underflow checker.
module uart_fifo_128x8 #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int THRESHOLD = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_fifo_128x8_if.slave   bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FullLevel = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ThLevel   = ADDR_W'(THRESHOLD);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] rdAddr_q;
    logic              rdbDly_q;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic [DATA_W-1:0] ramRdData;

    logic full;
    logic empty;
    logic wrAccept;
    logic rdAccept;

    // One slot is sacrificed so FULL can be decoded from a 7-bit count.
    assign full     = (count_q == FullLevel);
    assign empty    = (count_q == '0);
    assign wrAccept = ~bus.wrb_i & ~full;
    assign rdAccept = ~bus.rdb_i & ~empty;

    assign bus.full_o  = full;
    assign bus.empty_o = empty;
    assign bus.geqth_o = (count_q >= ThLevel);
    assign bus.data_o  = dataOut_q;

    always_ff @(posedge clk_i) begin
        if (wrAccept) begin
            mem[wrPtr_q] <= bus.data_i;
        end
    end

    assign ramRdData = mem[rdAddr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + AddrOne;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + AddrOne;
        end
        unique case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + AddrOne;
            2'b01:   count_d = count_q - AddrOne;
            default: count_d = count_q;
        endcase
    end

    // The output register loads one edge after the strobe, once the read address has settled.
    always_comb begin
        dataOut_d = dataOut_q;
        if (!rdbDly_q) begin
            dataOut_d = ramRdData;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            rdAddr_q  <= '0;
            rdbDly_q  <= 1'b0;
            dataOut_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            rdAddr_q  <= rdPtr_q;
            rdbDly_q  <= bus.rdb_i;
            dataOut_q <= dataOut_d;
        end
    end

`ifdef FIFO_OVERFLOW_CHECK_EN
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (!bus.wrb_i && full) begin
                $display("FIFO Overflow at time %0t", $time);
                $stop;
            end
            if (!bus.rdb_i && empty) begin
                $display("FIFO Underflow at time %0t", $time);
                $stop;
            end
        end
    end
`else
    // Illegal accesses are dropped silently by the accept gating above.
`endif

endmodule

// File: tb/tb_uart_fifo_128x8.sv
// Directed bench for uart_fifo_128x8: a vector table for the basic push/pop sequence,
// then queue-model driven sequences for threshold, full, wrap-around and mid-burst reset.
module tb_uart_fifo_128x8;
    logic clk;
    logic rstN;
    int   checks;
    int   failures;

    uart_fifo_128x8_if #(.DATA_W(8)) bus ();

    uart_fifo_128x8 #(.DATA_W(8), .ADDR_W(7), .THRESHOLD(64)) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wrb;
        logic       rdb;
        logic [7:0] data;
        logic       expEmpty;
        logic       expFull;
        logic       expGeqth;
        logic       chkData;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [10];

    logic [7:0] model [$];
    logic       prevRdbLow;
    logic       prevRdOk;
    logic [7:0] prevPopped;
    logic       expKnown;
    logic [7:0] expData;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wrb, input logic rdb, input logic [7:0] data);
        bus.wrb_i  = wrb;
        bus.rdb_i  = rdb;
        bus.data_i = data;
        @(posedge clk);
        #1;
    endtask

    // One cycle against the reference queue; data is only checked when the previous pop is known.
    task automatic modelCycle(input logic wrb, input logic rdb, input logic [7:0] data);
        logic       wrOk;
        logic       rdOk;
        logic [7:0] popped;
        wrOk   = !wrb && (model.size() < 127);
        rdOk   = !rdb && (model.size() != 0);
        popped = rdOk ? model[0] : 8'h00;
        applyStimulus(wrb, rdb, data);
        if (rdOk) void'(model.pop_front());
        if (wrOk) model.push_back(data);
        if (prevRdbLow) begin
            expKnown = prevRdOk;
            expData  = prevPopped;
        end
        prevRdbLow = !rdb;
        prevRdOk   = rdOk;
        prevPopped = popped;
        checkOutput("empty", {7'b0, bus.empty_o}, {7'b0, model.size() == 0});
        checkOutput("full",  {7'b0, bus.full_o},  {7'b0, model.size() == 127});
        checkOutput("geqth", {7'b0, bus.geqth_o}, {7'b0, model.size() >= 64});
        if (expKnown) checkOutput("data_out", bus.data_o, expData);
    endtask

    task automatic drainAll();
        int n;
        n = model.size();
        for (int i = 0; i < n; i++) modelCycle(1'b1, 1'b0, 8'h00);
        modelCycle(1'b1, 1'b1, 8'h00);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] dataCnt;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[6] = '{1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[7] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};

        bus.wrb_i  = 1'b1;
        bus.rdb_i  = 1'b1;
        bus.data_i = 8'h00;
        rstN       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_empty", {7'b0, bus.empty_o}, 8'h01);
        checkOutput("reset_full",  {7'b0, bus.full_o},  8'h00);
        checkOutput("reset_geqth", {7'b0, bus.geqth_o}, 8'h00);
        checkOutput("reset_data",  bus.data_o,          8'h00);
        rstN = 1'b1;

        $display("[TB] basic push/pop table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wrb, vecs[i].rdb, vecs[i].data);
            checkOutput($sformatf("vec%0d_empty", i), {7'b0, bus.empty_o}, {7'b0, vecs[i].expEmpty});
            checkOutput($sformatf("vec%0d_full", i),  {7'b0, bus.full_o},  {7'b0, vecs[i].expFull});
            checkOutput($sformatf("vec%0d_geqth", i), {7'b0, bus.geqth_o}, {7'b0, vecs[i].expGeqth});
            if (vecs[i].chkData) checkOutput($sformatf("vec%0d_data", i), bus.data_o, vecs[i].expData);
        end

        model.delete();
        prevRdbLow = 1'b0;
        prevRdOk   = 1'b0;
        prevPopped = 8'h00;
        expKnown   = 1'b1;
        expData    = 8'h11;

        $display("[TB] threshold crossing");
        for (int i = 0; i < 63; i++) modelCycle(1'b0, 1'b1, 8'h40 + 8'(i));
        checkOutput("geqth_at_63", {7'b0, bus.geqth_o}, 8'h00);
        modelCycle(1'b0, 1'b1, 8'h7F);
        checkOutput("geqth_at_64", {7'b0, bus.geqth_o}, 8'h01);
        modelCycle(1'b1, 1'b0, 8'h00);
        checkOutput("geqth_at_63_after_pop", {7'b0, bus.geqth_o}, 8'h00);
        drainAll();

        $display("[TB] fill to full");
        for (int i = 0; i < 127; i++) modelCycle(1'b0, 1'b1, 8'(i));
        checkOutput("full_at_127", {7'b0, bus.full_o}, 8'h01);
        modelCycle(1'b0, 1'b1, 8'hFF);
        checkOutput("full_after_ignored_write", {7'b0, bus.full_o}, 8'h01);
        modelCycle(1'b0, 1'b0, 8'hFE);
        checkOutput("full_after_rw_when_full", {7'b0, bus.full_o}, 8'h00);
        drainAll();
        checkOutput("empty_after_drain", {7'b0, bus.empty_o}, 8'h01);

        $display("[TB] sustained simultaneous read/write");
        dataCnt = 8'h00;
        for (int i = 0; i < 10; i++) begin
            modelCycle(1'b0, 1'b1, dataCnt);
            dataCnt++;
        end
        for (int i = 0; i < 200; i++) begin
            modelCycle(1'b0, 1'b0, dataCnt);
            dataCnt++;
        end
        checkOutput("level_kept_at_10", 8'(model.size()), 8'd10);
        checkOutput("not_empty_after_burst", {7'b0, bus.empty_o}, 8'h00);
        drainAll();

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 5; i++) modelCycle(1'b0, 1'b1, 8'hE0 + 8'(i));
        bus.wrb_i  = 1'b0;
        bus.data_i = 8'hE5;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_empty", {7'b0, bus.empty_o}, 8'h01);
        checkOutput("midreset_full",  {7'b0, bus.full_o},  8'h00);
        checkOutput("midreset_data",  bus.data_o,          8'h00);
        bus.wrb_i = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        model.delete();
        prevRdbLow = 1'b1;
        prevRdOk   = 1'b0;
        expKnown   = 1'b0;
        modelCycle(1'b0, 1'b1, 8'hAA);
        modelCycle(1'b0, 1'b1, 8'hBB);
        modelCycle(1'b0, 1'b1, 8'hCC);
        drainAll();
        checkOutput("post_reset_last_word", bus.data_o, 8'hCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
